// File: rtl/lzd11.sv
// rtl/lzd11.sv - registered leading-zero detector for an 11-bit operand
module lzd11 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [10:0] in,
    output logic        out_valid,
    output logic [3:0]  pos,
    output logic        zero
);

    // Ones are appended below bit 0 so a 16-bit tree count tops out at 11 for an all-zero operand.
    logic [15:0] padded;
    logic [1:0]  c4_3, c4_2, c4_1, c4_0;
    logic        v4_3, v4_2, v4_1;
    logic [2:0]  c8_hi, c8_lo;
    logic        v8_hi;
    logic [3:0]  pos_next;
    logic        zero_next;

    function automatic logic [1:0] nib_cnt(input logic [3:0] n);
        logic [1:0] c;
        if (n[3])
            c = 2'd0;
        else if (n[2])
            c = 2'd1;
        else if (n[1])
            c = 2'd2;
        else
            c = 2'd3;
        return c;
    endfunction

    assign padded = {in, 5'b11111};

    assign c4_3 = nib_cnt(padded[15:12]);
    assign c4_2 = nib_cnt(padded[11:8]);
    assign c4_1 = nib_cnt(padded[7:4]);
    assign c4_0 = nib_cnt(padded[3:0]);
    assign v4_3 = |padded[15:12];
    assign v4_2 = |padded[11:8];
    assign v4_1 = |padded[7:4];

    assign v8_hi = v4_3 | v4_2;
    assign c8_hi = v4_3 ? {1'b0, c4_3} : {1'b1, c4_2};
    assign c8_lo = v4_1 ? {1'b0, c4_1} : {1'b1, c4_0};

    assign pos_next  = v8_hi ? {1'b0, c8_hi} : {1'b1, c8_lo};
    assign zero_next = ~|in;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            pos       <= 4'd0;
            zero      <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                pos  <= pos_next;
                zero <= zero_next;
            end
        end
    end

endmodule

// File: tb/tb_lzd11.sv
// tb/tb_lzd11.sv - scoreboard bench for lzd11
module tb_lzd11;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [10:0] in;
    logic        out_valid;
    logic [3:0]  pos;
    logic        zero;

    int checks = 0;
    int fails  = 0;
    logic [4:0] sb[$];
    logic [3:0] last_pos;
    logic       last_zero;

    lzd11 dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in       (in),
        .out_valid(out_valid),
        .pos      (pos),
        .zero     (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] ref_lz(input logic [10:0] d);
        for (int i = 10; i >= 0; i--)
            if (d[i]) return 4'(10 - i);
        return 4'd11;
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input logic v, input string tag);
        logic [4:0] e;
        chk({tag, ".out_valid"}, {7'd0, out_valid}, {7'd0, v});
        if (v) begin
            if (sb.size() == 0) begin
                chk({tag, ".sb_empty"}, 8'd1, 8'd0);
            end else begin
                e = sb.pop_front();
                last_pos  = e[4:1];
                last_zero = e[0];
            end
        end
        chk({tag, ".pos"},  {4'd0, pos},  {4'd0, last_pos});
        chk({tag, ".zero"}, {7'd0, zero}, {7'd0, last_zero});
    endtask

    task automatic step(input logic v, input logic [10:0] d, input string tag);
        @(negedge clk);
        in_valid = v;
        in       = d;
        if (v) sb.push_back({ref_lz(d), d == 11'd0});
        @(posedge clk);
        #1;
        check_out(v, tag);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in        = 11'd0;
        last_pos  = 4'd0;
        last_zero = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_out(1'b0, "reset");
        @(negedge clk);
        rst_n = 1'b1;

        step(1'b1, 11'b00000000101, "basic");
        chk("basic.pos_const", {4'd0, pos}, 8'd8);

        for (int b = 10; b >= 0; b--) begin
            step(1'b1, 11'(1) << b, "sweep");
            chk("sweep.pos_const", {4'd0, pos}, 8'(10 - b));
        end

        step(1'b1, 11'b00000000000, "allzero");
        chk("allzero.pos_const", {4'd0, pos}, 8'd11);
        chk("allzero.zero_const", {7'd0, zero}, 8'd1);
        step(1'b1, 11'b11111111111, "allone");
        chk("allone.pos_const", {4'd0, pos}, 8'd0);

        step(1'b1, 11'b00001011011, "hold_src");
        for (int k = 0; k < 3; k++)
            step(1'b0, 11'($urandom), "hold");
        chk("hold.pos_const", {4'd0, pos}, 8'd4);

        step(1'b1, 11'b00100000000, "prerst");
        #2;
        rst_n = 1'b0;
        #1;
        last_pos  = 4'd0;
        last_zero = 1'b0;
        check_out(1'b0, "rst_async");
        @(negedge clk);
        in_valid = 1'b1;
        in       = 11'b00100000000;
        @(posedge clk);
        #1;
        check_out(1'b0, "rst_held");
        @(negedge clk);
        rst_n = 1'b1;
        in_valid = 1'b1;
        in       = 11'b00000010000;
        sb.push_back({ref_lz(in), 1'b0});
        @(posedge clk);
        #1;
        check_out(1'b1, "post_rst");
        chk("post_rst.pos_const", {4'd0, pos}, 8'd6);

        for (int k = 0; k < 10000; k++) begin
            logic [10:0] r;
            logic        v;
            r = 11'($urandom) >> $urandom_range(0, 11);
            v = ($urandom_range(0, 3) != 0);
            step(v, r, "random");
        end

        chk("sb_drained", 8'(sb.size()), 8'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/lzd11.md
LZD11 -- requirements
Module: lzd11

Interface
REQ-001 Parameters: none; input width fixed at 11 bits, count width fixed at 4 bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  qualifies `in` for capture on the current rising edge.
REQ-005 in  input  11  operand to scan; bit 10 is MSB.
REQ-006 out_valid  output  1  high for exactly one cycle per captured operand; qualifies pos/zero.
REQ-007 pos  output  4  registered leading-zero count of the captured operand, unsigned.
REQ-008 zero  output  1  registered flag, high when the captured operand is all zeros.

Function
REQ-009 pos SHALL equal the number of consecutive 0 bits from bit 10 downward before the first 1 bit; range 0..10 for non-zero operands.
REQ-010 Operand with bit 10 set SHALL give pos = 0 (4'b0000).
REQ-011 Operand with only bit 0 set SHALL give pos = 10 (4'b1010).
REQ-012 All-zero operand SHALL give pos = 11 (4'b1011) and zero = 1; any non-zero operand SHALL give zero = 0.
REQ-013 Bits below the leading 1 SHALL NOT affect pos.
REQ-014 Latency: operand sampled at rising edge N with in_valid = 1 SHALL appear on pos/zero with out_valid = 1 after edge N (visible in cycle N+1).
REQ-015 Throughput: one operand per cycle; back-to-back in_valid cycles SHALL give back-to-back out_valid cycles in input order.
REQ-016 Edge with in_valid = 0: out_valid SHALL go 0; pos and zero SHALL hold their previous values.
REQ-017 Count logic SHALL be purely combinational from `in` into the output registers; no other internal state.
REQ-018 No X propagation: with defined inputs, every output SHALL be defined whenever rst_n = 1.

Reset
REQ-019 While rst_n = 0: pos = 4'b0000, zero = 0, out_valid = 0, applied immediately without waiting for clk.
REQ-020 Assertion of rst_n mid-operation SHALL discard the in-flight result; no out_valid for that operand.
REQ-021 Sampling resumes on the first rising edge with rst_n = 1; in_valid on that edge SHALL be captured normally.

Verification
REQ-022 in = 11'b00000000101, in_valid = 1, one edge -> next cycle out_valid = 1, pos = 4'b1000, zero = 0.
REQ-023 Sweep single-hot operands, bit 10 down to bit 0, back-to-back -> pos = 0,1,...,10 on consecutive cycles, out_valid continuously 1, zero = 0.
REQ-024 in = 11'b00000000000 -> pos = 4'b1011, zero = 1; then in = 11'b11111111111 -> pos = 4'b0000, zero = 0.
REQ-025 Valid operand, then in_valid = 0 for 3 cycles with random `in` -> out_valid = 0 on those cycles, pos/zero unchanged.
REQ-026 rst_n pulled low between clock edges right after capturing 11'b00100000000 -> outputs zero immediately, no out_valid after release; next captured 11'b00000010000 -> pos = 4'b0110.
REQ-027 Random operands, 10k cycles -> pos/zero match a reference leading-zero count each valid cycle.
